mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Parametrised memory-port front end between CPU-side requestors (instruction fetch, data load/store, future DMA) and the single shared memory bus (readM / writeM / address / data). Arbitrates NUM_CH request channels, holds each access for a fixed MEM_LAT bus cycles, captures read data and returns a one-cycle response to the granted channel. It replaces direct single-master bus driving in the CPU top, and supports a halt-drain mode and an access counter.

## Interface
- WORD_W, 16: data word width (matches `SIZE_WORD)
- ADDR_W, 16: address width
- NUM_CH, 2: requestor channels, 1..8; channel 0 = fetch
- MEM_LAT, 2: cycles readM/writeM held per access, >= 1
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_CH  per-channel request
- req_write  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH*ADDR_W  packed, channel i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CH*WORD_W  packed write data
- req_ready  out  NUM_CH  one-hot grant pulse; request accepted this cycle
- rsp_valid  out  NUM_CH  one-hot completion pulse
- rsp_rdata  out  WORD_W  read data, valid with rsp_valid (held until next read completes)
- halt  in  1  stop issuing new grants
- is_idle  out  1  FSM in IDLE and no grant this cycle
- readM  out  1  bus read strobe
- writeM  out  1  bus write strobe
- address  out  ADDR_W  bus address
- data  inout  WORD_W  driven only while writeM = 1, else high-Z
- num_access  out  WORD_W  completed-access counter

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if halt = 0 and any req_valid, grant one channel (see arbitration), pulse its req_ready, latch addr/wdata/write, load lat_cnt = MEM_LAT, go ACCESS. Otherwise stay; is_idle = 1.
- ACCESS: readM = ~wr_l, writeM = wr_l, address = addr_l, data = wdata_l if write else Z. lat_cnt decrements each cycle; when lat_cnt = 1, reads capture data into rsp_rdata, go RESP.
- RESP: strobes low, data Z; rsp_valid[granted] = 1 for one cycle; num_access += 1 (wraps at 2^WORD_W); go IDLE.
- Arbitration (default): round-robin; search starts at last_grant+1 mod NUM_CH. last_grant resets to NUM_CH-1 so channel 0 wins first.
- req_valid deasserted after grant has no effect; request is latched.
- req_valid held after rsp_valid = a new request, re-arbitrated normally.
- halt asserted mid-access: current access completes including RESP; no further grants. halt sampled only in IDLE.
- Write responses: rsp_valid pulses; rsp_rdata unchanged.

## Timing
- Reset values: readM 0, writeM 0, address 0, data Z, req_ready 0, rsp_valid 0, rsp_rdata 0, num_access 0, is_idle 1, state IDLE, last_grant NUM_CH-1.
- Grant in cycle T (req_ready combinational from IDLE + req_valid), strobes high cycles T+1..T+MEM_LAT, rsp_valid in cycle T+MEM_LAT+1, next grant earliest T+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Read data sampled at the rising edge ending cycle T+MEM_LAT.
- reset_n low mid-access: at that edge all outputs take reset values; no rsp_valid for the aborted access; counter cleared.

## Configuration
- MEM_ARB_FIXED_PRIO_EN: if defined, arbitration is fixed priority (lowest index wins, last_grant unused). If undefined, round-robin as above.

## Structure
- Shared package/header: state encodings (IDLE/ACCESS/RESP), default WORD_W/ADDR_W tied to `SIZE_WORD, MEM_LAT default.
- One sub-module: mem_rr_picker (inputs req vector, last_grant; outputs one-hot grant + index; holds fixed-priority variant under the macro).

## Test plan
- Single read ch0, addr 0x0010, memory model returns 0xBEEF, MEM_LAT=2 -> readM high 2 cycles, rsp_valid[0] at T+3, rsp_rdata = 0xBEEF, num_access = 1.
- Write ch1, addr 0x0020, data 0x1234 -> writeM high 2 cycles, data bus = 0x1234 only then, Z otherwise; memory model holds 0x1234 at 0x20.
- ch0 and ch1 requesting continuously -> grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN -> always 0.
- halt raised one cycle after grant -> access completes, rsp_valid pulses, then no grants while halt = 1, is_idle = 1; release -> pending request granted.
- reset_n low during ACCESS cycle 1 -> readM/writeM 0, data Z next edge, no rsp_valid, num_access 0.
- MEM_LAT=1, NUM_CH=4, all valid -> grants 0,1,2,3,0 at 3-cycle spacing.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the memory-port front end: FSM state encoding,
// default bus widths (tied to `SIZE_WORD) and default access latency, plus
// a helper for sizing channel-index fields.
// Optional feature macro used by this slice: MEM_ARB_FIXED_PRIO_EN
// (fixed-priority arbitration instead of round-robin).
`ifndef SIZE_WORD
`define SIZE_WORD 16
`endif

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam int DEF_WORD_W  = `SIZE_WORD;
  localparam int DEF_ADDR_W  = `SIZE_WORD;
  localparam int DEF_MEM_LAT = 2;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// mem_rr_picker
// Combinational channel picker for mem_port_arbiter.
// Default: round-robin, search starts at last_grant+1 (mod NUM_CH).
// MEM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins and
// last_grant is ignored.
// Ports:
//   req        in  NUM_CH  request vector
//   last_grant in  IDX_W   index of the previously granted channel
//   grant      out NUM_CH  one-hot winner (all zero when no request)
//   grant_idx  out IDX_W   index of the winner
//   any        out 1       at least one request present
module mem_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any && req[i]) begin
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end
`else
  always_comb begin
    int c;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    c         = 0;
    // k = 1..NUM_CH visits every channel once, the previous winner last.
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(last_grant) + k) % NUM_CH;
      if (!any && req[c]) begin
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
        any       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Front end between NUM_CH requestors (channel 0 = fetch) and the single
// shared memory bus. One access at a time: grant, hold the strobe for
// MEM_LAT cycles, then a one-cycle response to the granted channel.
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN (see mem_rr_picker).
//
// Handshake: a channel requests by holding req_valid[i] high with its
// write/addr/wdata stable. req_ready[i] is a combinational one-cycle pulse
// meaning "accepted this cycle"; the request is latched on that edge, so
// req_valid may drop afterwards. Completion is a one-cycle rsp_valid[i]
// pulse; rsp_rdata is meaningful for reads and holds until the next read
// completes. A req_valid still high after rsp_valid is a fresh request.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/req_write     per-channel request and direction
//   req_addr/req_wdata      packed per-channel address / write data
//   req_ready, rsp_valid    one-hot grant / completion pulses
//   rsp_rdata               captured read data
//   halt, is_idle           grant inhibit (sampled in IDLE), idle flag
//   readM, writeM, address  bus strobes and address
//   data                    bidirectional bus data, driven only on writes
//   num_access              completed-access counter (wraps)
//   state_dbg               current FSM state
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_CH  = 2,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*WORD_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [WORD_W-1:0]        rsp_rdata,
  input  logic                     halt,
  output logic                     is_idle,
  output logic                     readM,
  output logic                     writeM,
  output logic [ADDR_W-1:0]        address,
  inout  wire  [WORD_W-1:0]        data,
  output logic [WORD_W-1:0]        num_access,
  output arb_state_t               state_dbg
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t        state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr_l;
  logic [WORD_W-1:0] wdata_l;
  logic              wr_l;
  logic [NUM_CH-1:0] gnt_l;
  logic [IDX_W-1:0]  last_grant;

  logic [NUM_CH-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              grant_fire;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;

  mem_rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_gnt),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  // One-hot mux of the winning channel's address and write data.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    req_ready  = '0;
    rsp_valid  = '0;
    is_idle    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!halt && pick_any) begin
          grant_fire = 1'b1;
          req_ready  = pick_gnt;
          state_nxt  = ST_ACCESS;
        end else begin
          is_idle = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (lat_cnt == LAT_W'(1)) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = gnt_l;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      addr_l     <= '0;
      wdata_l    <= '0;
      wr_l       <= 1'b0;
      gnt_l      <= '0;
      last_grant <= IDX_W'(NUM_CH - 1);
      rsp_rdata  <= '0;
      num_access <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            lat_cnt    <= LAT_W'(MEM_LAT);
            addr_l     <= sel_addr;
            wdata_l    <= sel_wdata;
            wr_l       <= |(pick_gnt & req_write);
            gnt_l      <= pick_gnt;
            last_grant <= pick_idx;
          end
        end
        ST_ACCESS: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          // Last strobe cycle: the edge ending it samples read data.
          if (lat_cnt == LAT_W'(1) && !wr_l) rsp_rdata <= data;
        end
        ST_RESP: num_access <= num_access + WORD_W'(1);
        default: ;
      endcase
    end
  end

  assign readM     = (state == ST_ACCESS) && !wr_l;
  assign writeM    = (state == ST_ACCESS) && wr_l;
  assign address   = (state == ST_ACCESS) ? addr_l : '0;
  assign data      = writeM ? wdata_l : {WORD_W{1'bz}};
  assign state_dbg = state;

endmodule
